sprite_blitter: RTL

Draw-command engine that produces the pixel-write stream consumed by the SRAM controller's program-write port (`program_x`/`program_y`/`program_data`). It accepts one sprite-draw command at a time over a valid/ready handshake. For each command it fetches the sprite bitmap from an on-chip sprite ROM and presents one pixel per controller write slot. Transparent and off-screen pixels are replaced by a parked, harmless address. It sits between the game logic and the SRAM controller and always writes into the hidden frame.

---
 rtl/boxhead_pkg.sv | 14 +
 rtl/sprite_blitter_if.sv | 14 +
 rtl/sprite_rom.sv | 20 ++
 rtl/sprite_blitter.sv | 99 +++++++++
 4 files changed

// File: rtl/boxhead_pkg.sv
// boxhead_pkg: screen geometry plus the blitter state and command types shared across the design.
package boxhead_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [9:0] PARK_X = 10'h3FF;
  localparam int BLIT_IDW = 4;
  typedef enum logic [1:0] {IDLE, PRIME, DRAW, DRAIN} blit_state_e;
  typedef struct packed {
    logic [9:0]          x;
    logic [9:0]          y;
    logic [BLIT_IDW-1:0] id;
    logic                flip_x;
  } blit_cmd_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: draw-command valid/ready channel from game logic (master) to the blitter (slave).
interface sprite_blitter_if #(
  parameter int SPRITE_COUNT = 16
);
  localparam int IDW = $clog2(SPRITE_COUNT);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [9:0]     cmd_x;
  logic [9:0]     cmd_y;
  logic [IDW-1:0] cmd_id;
  logic           cmd_flip_x;
  modport master (output cmd_valid, cmd_x, cmd_y, cmd_id, cmd_flip_x, input cmd_ready);
  modport slave (input cmd_valid, cmd_x, cmd_y, cmd_id, cmd_flip_x, output cmd_ready);
endinterface

// File: rtl/sprite_rom.sv
// sprite_rom: sprite bitmap store with a synchronous one-cycle read at address {id, row, col}.
module sprite_rom #(
  parameter int          IDW         = 4,
  parameter int          RW          = 5,
  parameter int          CW          = 5,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic                 clk,
  input  logic [IDW+RW+CW-1:0] addr_i,
  output logic [15:0]          data_o
);
  localparam int AW = IDW + RW + CW;
  // Built-in bitmaps: sprite 0 solid green, sprite 1 keyed out along column 0, the rest encode their address
  function automatic logic [15:0] bitmap(input logic [AW-1:0] a);
    if (a[AW-1:RW+CW] == '0) return 16'h07E0;
    if (a[AW-1:RW+CW] == IDW'(1) && a[CW-1:0] == '0) return TRANSPARENT;
    return 16'h8000 | 16'(a);
  endfunction
  always_ff @(posedge clk) data_o <= bitmap(addr_i);
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: sprite draw engine streaming one pixel per controller write slot into the hidden frame.
// Define BLIT_CLIP_EN to park pixels that fall outside the 640x480 screen.
module sprite_blitter
  import boxhead_pkg::*;
#(
  parameter int          SPRITE_W     = 32,
  parameter int          SPRITE_H     = 32,
  parameter int          SPRITE_COUNT = 16,
  parameter logic [15:0] TRANSPARENT  = 16'hF81F
) (
  input  logic            sram_clk,
  input  logic            reset_n,
  input  logic            frame_clk,
  input  logic            write_slot,
  sprite_blitter_if.slave cmd,
  output logic            busy,
  output logic [9:0]      program_x,
  output logic [9:0]      program_y,
  output logic [15:0]     program_data
);
  localparam int IDW = $clog2(SPRITE_COUNT);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int PW = RW + CW;
  localparam logic [35:0] PARK = {PARK_X, 10'd0, 16'd0};
  blit_state_e state_q, state_d;
  blit_cmd_t cmd_q, cmd_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [35:0] prog_q, prog_d;
  logic frame_q, edge_q, clip;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q;
  logic [9:0] pix_x, pix_y;
  logic [15:0] rom_data;
  assign col_q = pix_q[CW-1:0];
  assign row_q = pix_q[PW-1:CW];
  assign col_d = pix_d[CW-1:0];
  // Addressing from next-state keeps ROM data aligned with pixel pix_q, so adjacent slots work
  sprite_rom #(.IDW(IDW), .RW(RW), .CW(CW), .TRANSPARENT(TRANSPARENT)) u_rom (
    .clk   (sram_clk),
    .addr_i({cmd_d.id, pix_d[PW-1:CW], cmd_d.flip_x ? ~col_d : col_d}),
    .data_o(rom_data)
  );
`ifdef BLIT_CLIP_EN
  logic [10:0] x_sum, y_sum;
  assign x_sum = 11'(cmd_q.x) + 11'(col_q);
  assign y_sum = 11'(cmd_q.y) + 11'(row_q);
  assign clip = x_sum >= 11'(SCREEN_W) || y_sum >= 11'(SCREEN_H);
  assign pix_x = x_sum[9:0];
  assign pix_y = y_sum[9:0];
`else
  assign clip = 1'b0;
  assign pix_x = cmd_q.x + 10'(col_q);
  assign pix_y = cmd_q.y + 10'(row_q);
`endif
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    pix_d = pix_q;
    prog_d = prog_q;
    if (edge_q) begin
      state_d = IDLE;
      prog_d = PARK;
    end else if (state_q == IDLE && cmd.cmd_valid) begin
      state_d = PRIME;
      cmd_d = '{x: cmd.cmd_x, y: cmd.cmd_y, id: cmd.cmd_id, flip_x: cmd.cmd_flip_x};
      pix_d = '0;
    end else if (state_q == PRIME) begin
      state_d = DRAW;
    end else if (write_slot && state_q == DRAW) begin
      state_d = &pix_q ? DRAIN : DRAW;
      pix_d = pix_q + PW'(1);
      prog_d = (rom_data == TRANSPARENT || clip) ? PARK : {pix_x, pix_y, rom_data};
    end else if (write_slot && state_q == DRAIN) begin
      state_d = IDLE;
      prog_d = PARK;
    end
  end
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q <= '0;
      pix_q <= '0;
      prog_q <= PARK;
      frame_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      pix_q <= pix_d;
      prog_q <= prog_d;
      frame_q <= frame_clk;
      edge_q <= frame_clk & ~frame_q;
    end
  end
  assign cmd.cmd_ready = state_q == IDLE && !edge_q;
  assign busy = state_q != IDLE;
  assign {program_x, program_y, program_data} = prog_q;
endmodule
